// File: rtl/ppe_rr_grant_ctrl_pkg.sv
// Shared constants and types for the round-robin grant controller around the
// 512-wide pipelined programmable priority encoder (PPE).
//   W        request vector width (power of two)
//   IW       index width, log2(W)
//   LAT      PPE latency: edges from launch to the edge that registers its result
//   CNT_LOAD WAIT count; the result is registered LAT edges after launch and
//            sampled on the edge after that
package ppe_rr_grant_ctrl_pkg;
   localparam int W        = 512;
   localparam int IW       = $clog2(W);
   localparam int LAT      = 3;
   localparam int CNT_LOAD = LAT + 1;
   localparam int CNT_W    = $clog2(CNT_LOAD + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_OFFER = 2'd2
   } state_t;
endpackage

// File: rtl/ppe_rr_grant_ctrl_if.sv
// Signal bundle between the grant controller, the PPE and the grant consumer.
//   req_set         request pulses into the pending vector
//   pending         registered pending vector
//   ppe_req/p_enc   snapshot and pointer launched into the PPE
//   ppe_o_value*    PPE winner index and index+1, ppe_valid = winner found
//   gnt_*           valid/ready grant with one-hot decode
//   busy            controller not idle
// slave: controller view, master: environment view.
interface ppe_rr_grant_ctrl_if;
   import ppe_rr_grant_ctrl_pkg::*;

   logic [W-1:0]  req_set;
   logic [W-1:0]  pending;
   logic [W-1:0]  ppe_req;
   logic [IW-1:0] ppe_p_enc;
   logic [IW-1:0] ppe_o_value;
   logic [IW-1:0] ppe_o_value_inc;
   logic          ppe_valid;
   logic          gnt_valid;
   logic          gnt_ready;
   logic [IW-1:0] gnt_idx;
   logic [W-1:0]  gnt_onehot;
   logic          busy;

   modport slave (
      input  req_set, ppe_o_value, ppe_o_value_inc, ppe_valid, gnt_ready,
      output pending, ppe_req, ppe_p_enc, gnt_valid, gnt_idx, gnt_onehot, busy
   );

   modport master (
      output req_set, ppe_o_value, ppe_o_value_inc, ppe_valid, gnt_ready,
      input  pending, ppe_req, ppe_p_enc, gnt_valid, gnt_idx, gnt_onehot, busy
   );
endinterface

// File: rtl/ppe_rr_grant_ctrl_idx_decoder.sv
// IW-to-W one-hot decoder, the inverse of the PPE's 512-to-9 encoder.
//   idx     index in
//   onehot  single bit set at position idx
module idx_decoder_9_to_512
   import ppe_rr_grant_ctrl_pkg::*;
(
   input  logic [IW-1:0] idx,
   output logic [W-1:0]  onehot
);
   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end
endmodule

// File: rtl/ppe_rr_grant_ctrl.sv
// Round-robin grant controller around the pipelined PPE. Accumulates request
// pulses, launches a snapshot + pointer into the PPE, waits the PPE latency,
// then offers the winner as a valid/ready grant. Acceptance clears the served
// bit and moves the pointer to winner + 1.
//   clk, rst  clock, asynchronous active-high reset
//   bus       ppe_rr_grant_ctrl_if.slave (requests, PPE launch/result, grant)
//
// state    | meaning
// ST_IDLE  | no lookup in flight; launch when anything is pending
// ST_WAIT  | snapshot held on the PPE inputs, counting down to the result
// ST_OFFER | grant presented downstream until accepted
module ppe_rr_grant_ctrl
   import ppe_rr_grant_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   ppe_rr_grant_ctrl_if.slave bus
);
   state_t           state_q, state_d;
   logic [W-1:0]     pending_q, pending_d;
   logic [W-1:0]     ppe_req_q, ppe_req_d;
   logic [IW-1:0]    ppe_p_enc_q, ppe_p_enc_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    nxt_ptr_q, nxt_ptr_d;
   logic [IW-1:0]    gnt_idx_q, gnt_idx_d;
   logic [W-1:0]     gnt_onehot_q, gnt_onehot_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic [W-1:0]     clr;
   logic [W-1:0]     idx_onehot;

   // Decodes the next grant index; the registered copy doubles as the clear mask.
   idx_decoder_9_to_512 u_idx_dec (
      .idx    (gnt_idx_d),
      .onehot (idx_onehot)
   );

   always_comb begin
      state_d     = state_q;
      ppe_req_d   = ppe_req_q;
      ppe_p_enc_d = ppe_p_enc_q;
      ptr_d       = ptr_q;
      nxt_ptr_d   = nxt_ptr_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      cnt_d       = cnt_q;

      accept = gnt_valid_q & bus.gnt_ready;
      clr    = accept ? gnt_onehot_q : '0;
      // set wins over clear for the same bit
      pending_d = (pending_q & ~clr) | bus.req_set;

      case (state_q)
         ST_IDLE: begin
            if (pending_q != '0) begin
               ppe_req_d   = pending_q;
               ppe_p_enc_d = ptr_q;
               cnt_d       = CNT_W'(CNT_LOAD);
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (bus.ppe_valid) begin
                  gnt_idx_d   = bus.ppe_o_value;
                  nxt_ptr_d   = bus.ppe_o_value_inc;
                  gnt_valid_d = 1'b1;
                  state_d     = ST_OFFER;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_OFFER: begin
            if (accept) begin
               gnt_valid_d = 1'b0;
               ptr_d       = nxt_ptr_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      gnt_onehot_d = gnt_valid_d ? idx_onehot : '0;
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         ppe_req_q    <= '0;
         ppe_p_enc_q  <= '0;
         ptr_q        <= '0;
         nxt_ptr_q    <= '0;
         gnt_idx_q    <= '0;
         gnt_onehot_q <= '0;
         gnt_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         ppe_req_q    <= ppe_req_d;
         ppe_p_enc_q  <= ppe_p_enc_d;
         ptr_q        <= ptr_d;
         nxt_ptr_q    <= nxt_ptr_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_onehot_q <= gnt_onehot_d;
         gnt_valid_q  <= gnt_valid_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.pending    = pending_q;
   assign bus.ppe_req    = ppe_req_q;
   assign bus.ppe_p_enc  = ppe_p_enc_q;
   assign bus.gnt_valid  = gnt_valid_q;
   assign bus.gnt_idx    = gnt_idx_q;
   assign bus.gnt_onehot = gnt_onehot_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ppe_rr_grant_ctrl.sv
// Bench for ppe_rr_grant_ctrl: a PPE stand-in with LAT register stages
// (result registered LAT edges after launch) and a set/pointer reference model.
module tb_ppe_rr_grant_ctrl;
   import ppe_rr_grant_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ppe_rr_grant_ctrl_if bus ();

   ppe_rr_grant_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc_cnt     = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- PPE stand-in: rotate from pointer, first set bit wins
   function automatic int rot_pick(input logic [W-1:0] r, input logic [IW-1:0] p);
      for (int k = 0; k < W; k++) begin
         if (r[(int'(p) + k) % W]) return (int'(p) + k) % W;
      end
      return -1;
   endfunction

   int            ppe_pick;
   logic          pv [LAT];
   logic [IW-1:0] pi [LAT];

   always_comb ppe_pick = rot_pick(bus.ppe_req, bus.ppe_p_enc);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            pv[i] <= 1'b0;
            pi[i] <= '0;
         end
      end else begin
         pv[0] <= (ppe_pick >= 0);
         pi[0] <= IW'(ppe_pick);
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pi[i] <= pi[i-1];
         end
      end
   end

   assign bus.ppe_valid       = pv[LAT-1];
   assign bus.ppe_o_value     = pi[LAT-1];
   assign bus.ppe_o_value_inc = pi[LAT-1] + IW'(1);

   // ---------------- reference model: lowest pending >= ptr, else lowest overall
   logic [W-1:0] mset;
   int           mptr;

   function automatic int ref_pick(input logic [W-1:0] s, input int p);
      for (int i = p; i < W; i++) if (s[i]) return i;
      for (int i = 0; i < W; i++) if (s[i]) return i;
      return -1;
   endfunction

   // ---------------- stimulus helpers (all called at a negedge)
   task automatic pulse(input logic [W-1:0] bits);
      bus.req_set = bits;
      @(negedge clk);
      bus.req_set = '0;
   endtask

   // Waits for a launch, records pointer and launch cycle, then waits for the grant.
   task automatic run_grant(output int idx, output int penc, output int lat,
                            output int t_launch, output bit ok);
      int n;
      ok = 1'b0; idx = -1; penc = -1; lat = 0; t_launch = 0; n = 0;
      while (bus.busy !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy !== 1'b1) return;
      penc     = int'(bus.ppe_p_enc);
      t_launch = cyc_cnt;
      while (bus.gnt_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (bus.gnt_valid !== 1'b1) return;
      idx = int'(bus.gnt_idx);
      ok  = 1'b1;
   endtask

   // ---------------- tests
   task automatic test_reset();
      bus.req_set   = '0;
      bus.gnt_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.pending !== '0 || bus.ppe_req !== '0 || bus.ppe_p_enc !== '0 ||
          bus.gnt_valid !== 1'b0 || bus.gnt_idx !== '0 || bus.gnt_onehot !== '0 ||
          bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b idx=%0d busy=%b p_enc=%0d required all zero",
                  bus.gnt_valid, bus.gnt_idx, bus.busy, bus.ppe_p_enc);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [W-1:0] e, oh;
      int idx, penc, lat, t0, t1, bad;
      bit ok;
      bus.gnt_ready = 1'b1;
      e = '0; e[5] = 1'b1; e[300] = 1'b1;
      pulse(e);
      vectors++;
      if (bus.pending !== e) begin
         miscompares++;
         $display("FAIL basic_pending_set: got %h required %h", bus.pending, e);
      end
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 5 || penc != 0) begin
         miscompares++;
         $display("FAIL basic_grant0: ok=%b idx=%0d p_enc=%0d required idx=5 p_enc=0", ok, idx, penc);
      end
      vectors++;
      if (lat != LAT + 1) begin
         miscompares++;
         $display("FAIL launch_to_grant_cycles: got %0d required %0d", lat, LAT + 1);
      end
      oh = '0; oh[5] = 1'b1;
      vectors++;
      if (bus.gnt_onehot !== oh) begin
         miscompares++;
         $display("FAIL basic_onehot5: got %h required %h", bus.gnt_onehot, oh);
      end
      @(negedge clk);
      e[5] = 1'b0;
      vectors++;
      if (bus.pending !== e) begin
         miscompares++;
         $display("FAIL basic_clear5: got %h required %h", bus.pending, e);
      end
      run_grant(idx, penc, lat, t1, ok);
      vectors++;
      if (!ok || idx != 300 || penc != 6) begin
         miscompares++;
         $display("FAIL basic_grant1: ok=%b idx=%0d p_enc=%0d required idx=300 p_enc=6", ok, idx, penc);
      end
      vectors++;
      if (t1 - t0 != LAT + 3) begin
         miscompares++;
         $display("FAIL grant_period: got %0d required %0d", t1 - t0, LAT + 3);
      end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.busy !== 1'b0 || bus.gnt_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      vectors++;
      if (bus.pending !== '0 || bad != 0) begin
         miscompares++;
         $display("FAIL basic_drained: pending_nonzero=%b active_cycles=%0d required 0/0",
                  bus.pending != '0, bad);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] e;
      int idx, penc, lat, t0;
      bit ok;
      bus.gnt_ready = 1'b1;
      e = '0; e[5] = 1'b1; e[300] = 1'b1;
      pulse(e);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 5 || penc != 301) begin
         miscompares++;
         $display("FAIL wrap_grant: ok=%b idx=%0d p_enc=%0d required idx=5 p_enc=301", ok, idx, penc);
      end
      @(negedge clk);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 300 || penc != 6) begin
         miscompares++;
         $display("FAIL wrap_ptr6: ok=%b idx=%0d p_enc=%0d required idx=300 p_enc=6", ok, idx, penc);
      end
      @(negedge clk);
   endtask

   task automatic test_boundary();
      logic [W-1:0] e;
      int idx, penc, lat, t0;
      bit ok;
      bus.gnt_ready = 1'b1;
      e = '0; e[511] = 1'b1;
      pulse(e);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 511 || bus.gnt_onehot !== e) begin
         miscompares++;
         $display("FAIL boundary_511: ok=%b idx=%0d onehot_ok=%b required idx=511",
                  ok, idx, bus.gnt_onehot === e);
      end
      @(negedge clk);
      e = '0; e[3] = 1'b1;
      pulse(e);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 3 || penc != 0) begin
         miscompares++;
         $display("FAIL boundary_ptr_wrap: ok=%b idx=%0d p_enc=%0d required idx=3 p_enc=0", ok, idx, penc);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] e, e7, oh;
      int idx, penc, lat, t0, bad;
      bit ok;
      bus.gnt_ready = 1'b0;
      e = '0; e[20] = 1'b1;
      e7 = '0; e7[7] = 1'b1;
      oh = e;
      pulse(e);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 20 || penc != 4) begin
         miscompares++;
         $display("FAIL stall_grant: ok=%b idx=%0d p_enc=%0d required idx=20 p_enc=4", ok, idx, penc);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         bus.req_set = (i == 3) ? e7 : '0;
         @(negedge clk);
         if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== IW'(20) || bus.gnt_onehot !== oh) bad++;
      end
      bus.req_set = '0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stall_hold: got %0d disturbed cycles required 0", bad);
      end
      vectors++;
      if (bus.pending !== (e | e7)) begin
         miscompares++;
         $display("FAIL stall_pending: got %h required %h", bus.pending, e | e7);
      end
      bus.gnt_ready = 1'b1;
      @(negedge clk);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 7 || penc != 21) begin
         miscompares++;
         $display("FAIL stall_next: ok=%b idx=%0d p_enc=%0d required idx=7 p_enc=21", ok, idx, penc);
      end
      @(negedge clk);
   endtask

   task automatic test_collision();
      logic [W-1:0] e;
      int idx, penc, lat, t0;
      bit ok;
      bus.gnt_ready = 1'b0;
      e = '0; e[5] = 1'b1;
      pulse(e);
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 5 || penc != 8) begin
         miscompares++;
         $display("FAIL collide_grant: ok=%b idx=%0d p_enc=%0d required idx=5 p_enc=8", ok, idx, penc);
      end
      bus.gnt_ready = 1'b1;
      bus.req_set   = e;
      @(negedge clk);
      bus.req_set   = '0;
      bus.gnt_ready = 1'b0;
      vectors++;
      if (bus.gnt_valid !== 1'b0 || bus.pending !== e) begin
         miscompares++;
         $display("FAIL collide_set_wins: valid=%b bit5=%b required valid=0 bit5=1",
                  bus.gnt_valid, bus.pending[5]);
      end
      run_grant(idx, penc, lat, t0, ok);
      vectors++;
      if (!ok || idx != 5 || penc != 6) begin
         miscompares++;
         $display("FAIL collide_regrant: ok=%b idx=%0d p_enc=%0d required idx=5 p_enc=6", ok, idx, penc);
      end
      bus.gnt_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      logic [W-1:0] e;
      int n, bad;
      bus.gnt_ready = 1'b1;
      e = '0; e[10] = 1'b1;
      pulse(e);
      n = 0;
      while (bus.busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (bus.pending !== '0 || bus.ppe_req !== '0 || bus.ppe_p_enc !== '0 ||
          bus.gnt_valid !== 1'b0 || bus.gnt_idx !== '0 || bus.gnt_onehot !== '0 ||
          bus.busy !== 1'b0 || n >= 20) begin
         miscompares++;
         $display("FAIL reset_mid_wait: busy=%b p_enc=%0d idx=%0d launch_wait=%0d required zeros",
                  bus.busy, bus.ppe_p_enc, bus.gnt_idx, n);
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL post_reset_quiet: got %0d active cycles required 0", bad);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] s, inj, oh;
      int idx, penc, lat, t0, exp, k, stall, guard;
      bit ok;
      mset = '0;
      mptr = 0;
      for (int r = 0; r < 8; r++) begin
         s = '0;
         k = int'($urandom_range(1, 5));
         for (int j = 0; j < k; j++) s[int'($urandom_range(0, W - 1))] = 1'b1;
         mset = mset | s;
         bus.gnt_ready = 1'b0;
         pulse(s);
         guard = 0;
         while (mset != '0 && guard < 20) begin
            guard++;
            exp = ref_pick(mset, mptr);
            run_grant(idx, penc, lat, t0, ok);
            vectors++;
            if (!ok || idx != exp || penc != mptr || lat != LAT + 1) begin
               miscompares++;
               $display("FAIL random_grant r%0d: ok=%b idx=%0d p_enc=%0d lat=%0d required idx=%0d p_enc=%0d lat=%0d",
                        r, ok, idx, penc, lat, exp, mptr, LAT + 1);
            end
            oh = '0; oh[exp] = 1'b1;
            vectors++;
            if (bus.gnt_onehot !== oh) begin
               miscompares++;
               $display("FAIL random_onehot r%0d: onehot_ok=%b required bit %0d", r, 1'b0, exp);
            end
            stall = int'($urandom_range(0, 3));
            for (int j = 0; j < stall; j++) begin
               inj = '0;
               if (j == 0 && $urandom_range(0, 9) < 3) inj[int'($urandom_range(0, W - 1))] = 1'b1;
               mset = mset | inj;
               bus.req_set = inj;
               @(negedge clk);
            end
            bus.req_set   = '0;
            bus.gnt_ready = 1'b1;
            @(negedge clk);
            bus.gnt_ready = 1'b0;
            mset[exp] = 1'b0;
            mptr = (exp + 1) % W;
            if (!ok) mset = '0;
         end
         vectors++;
         if (bus.pending !== mset) begin
            miscompares++;
            $display("FAIL random_drain r%0d: pending_nonzero=%b required empty", r, bus.pending != '0);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_set   = '0;
      bus.gnt_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_boundary();
      test_backpressure();
      test_collision();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
